chip8_mem: RTL



---
 rtl/chip8_pkg.sv | 40 ++++
 rtl/chip8_ram.sv | 23 ++
 rtl/chip8_mem.sv | 134 +++++++++++++
 3 files changed

// File: rtl/chip8_pkg.sv
// Shared definitions for the CHIP-8 memory responder: sequencer states,
// default base addresses and the built-in hex font.
package chip8_pkg;

  typedef enum logic [1:0] {
    ST_FONT  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  localparam int FONT_BYTES = 80;
  localparam logic [11:0] FONT_BASE_DEF = 12'h000;
  localparam logic [11:0] PROG_BASE_DEF = 12'h200;

  // Glyphs 0-F, five rows each, index 0 is the top row of glyph 0.
  localparam logic [0:FONT_BYTES-1][7:0] FONT_ROM = {
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,
    8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,
    8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,
    8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,
    8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,
    8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,
    8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

  function automatic logic [7:0] font_byte(input logic [6:0] idx);
    return (int'(idx) < FONT_BYTES) ? FONT_ROM[idx] : 8'h00;
  endfunction

endpackage

// File: rtl/chip8_ram.sv
// Byte RAM for the CHIP-8 responder: one synchronous write port and one
// combinational read port; contents are deliberately not reset.
module chip8_ram #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/chip8_mem.sv
// CHIP-8 memory responder: font sequencer, host program loader, CPU port.
// Define CHIP8_MEM_CLEAR_EN to zero all non-font RAM before the host load.
//
// state | meaning
// FONT  | sequencer writes the 80 font bytes, one per cycle
// CLEAR | sequencer zeroes FONT_BASE+80 .. MEM_DEPTH-1 (CHIP8_MEM_CLEAR_EN only)
// LOAD  | host program bytes accepted at PROG_BASE onwards
// RUN   | CPU owns the RAM, cpu_hold released
module chip8_mem
  import chip8_pkg::*;
#(
  parameter int                ADDR_W    = 12,
  parameter int                MEM_DEPTH = 4096,
  parameter logic [ADDR_W-1:0] FONT_BASE = FONT_BASE_DEF,
  parameter logic [ADDR_W-1:0] PROG_BASE = PROG_BASE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [7:0]        mem_data_in,
  output logic [7:0]        mem_data_out,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   load_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] FONT_LAST   = ADDR_W'(FONT_BYTES - 1);
  localparam logic [ADDR_W-1:0] CLEAR_START = FONT_BASE + ADDR_W'(FONT_BYTES);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] seq_q, seq_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wdata;
  logic [ADDR_W-1:0] load_addr;

  // Read data is always driven, so the strobe carries no information here.
  logic unused_read;
  assign unused_read = mem_read;

  assign load_addr = PROG_BASE + cnt_q[ADDR_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FONT;
      seq_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    waddr   = seq_q;
    wdata   = 8'h00;
    case (state_q)
      ST_FONT: begin
        we    = 1'b1;
        waddr = FONT_BASE + seq_q;
        wdata = font_byte(seq_q[6:0]);
        if (seq_q == FONT_LAST) begin
`ifdef CHIP8_MEM_CLEAR_EN
          state_d = ST_CLEAR;
          seq_d   = CLEAR_START;
`else
          state_d = ST_LOAD;
          seq_d   = '0;
`endif
        end else begin
          seq_d = seq_q + 1'b1;
        end
      end
      ST_CLEAR: begin
`ifdef CHIP8_MEM_CLEAR_EN
        we = 1'b1;
        if (seq_q == LAST_ADDR) begin
          state_d = ST_LOAD;
          seq_d   = '0;
        end else begin
          seq_d = seq_q + 1'b1;
        end
`else
        state_d = ST_LOAD;
`endif
      end
      ST_LOAD: begin
        if (load_valid) begin
          we    = 1'b1;
          waddr = load_addr;
          wdata = load_data;
          cnt_d = cnt_q + 1'b1;
          // Writing the top byte ends the load so the address never wraps.
          if (load_last || load_addr == LAST_ADDR) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        we    = mem_write;
        waddr = mem_addr_in;
        wdata = mem_data_in;
      end
      default: state_d = ST_FONT;
    endcase
  end

  assign load_ready = (state_q == ST_LOAD);
  assign cpu_hold   = (state_q != ST_RUN);
  assign load_count = cnt_q;

  chip8_ram #(
    .ADDR_W (ADDR_W),
    .DEPTH  (MEM_DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (mem_addr_in),
    .rdata_o (mem_data_out)
  );

endmodule
